// File: rtl/kalman_scheduler.sv
// Round-robin scheduler sharing one Kalman update core across N_CH channels.
// Holds per-channel pending samples and x/p state; Q/R changes apply between updates.
module kalman_scheduler #(
  parameter int N_CH    = 3,
  parameter int MEAS_W  = 14,
  parameter int DW      = 32,
  parameter int P_INIT  = 1,
  parameter int Q_INIT  = 5,
  parameter int R_INIT  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_CH-1:0]        i_meas_vld,
  input  logic [N_CH*MEAS_W-1:0] i_meas,
  input  logic [N_CH-1:0]        i_ch_clr,
  input  logic                   i_cfg_wr,
  input  logic [DW-1:0]          i_cfg_Q,
  input  logic [DW-1:0]          i_cfg_R,
  input  logic                   i_ovf_clr,
  output logic                   o_core_start,
  output logic [MEAS_W-1:0]      o_core_meas,
  output logic [DW-1:0]          o_core_x,
  output logic [DW-1:0]          o_core_p,
  output logic [DW-1:0]          o_core_Q,
  output logic [DW-1:0]          o_core_R,
  input  logic                   i_core_done,
  input  logic [DW-1:0]          i_core_x,
  input  logic [DW-1:0]          i_core_p,
  output logic [N_CH*DW-1:0]     o_x_est,
  output logic [N_CH*DW-1:0]     o_p_est,
  output logic [N_CH-1:0]        o_est_vld,
  output logic [N_CH-1:0]        o_meas_ovf,
  output logic                   o_timeout,
  output logic                   o_busy
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [MEAS_W-1:0] r_meas [N_CH];
  logic [DW-1:0]     r_x [N_CH];
  logic [DW-1:0]     r_p [N_CH];
  logic [N_CH-1:0]   r_pend, r_ovf;
  logic [CW-1:0]     r_ch, r_last;
  logic [TW-1:0]     r_cnt;
  logic              r_abort, r_timeout;
  logic              r_cfg_pend;
  logic [DW-1:0]     r_q_act, r_r_act, r_q_sh, r_r_sh;
  logic [MEAS_W-1:0] r_op_meas;
  logic [DW-1:0]     r_op_x, r_op_p, r_op_q, r_op_r;

  logic [MEAS_W-1:0] w_meas [N_CH];
  logic [N_CH-1:0]   w_req;
  logic [CW-1:0]     w_gnt;
  logic              w_gnt_vld;
  logic [MEAS_W-1:0] w_gnt_meas;
  logic [DW-1:0]     w_gnt_x, w_gnt_p;
  logic              w_grant, w_wb, w_tmo, w_abort_set, w_apply;

  always_comb begin
    o_x_est = '0;
    o_p_est = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_meas[k] = i_meas[k*MEAS_W +: MEAS_W];
      o_x_est[k*DW +: DW] = r_x[k];
      o_p_est[k*DW +: DW] = r_p[k];
    end
  end

  // Walk from farthest to nearest offset so the first pending after last wins.
  always_comb begin : p_gnt
    int j;
    j = 0;
    w_req = r_pend & ~i_ch_clr;
    w_gnt_vld = |w_req;
    w_gnt = '0;
    w_gnt_meas = '0;
    w_gnt_x = '0;
    w_gnt_p = '0;
    for (int i = N_CH; i >= 1; i--) begin
      j = int'(r_last) + i;
      if (j >= N_CH) j = j - N_CH;
      if (w_req[j]) begin
        w_gnt = CW'(j);
        w_gnt_meas = i_meas_vld[j] ? w_meas[j] : r_meas[j];
        w_gnt_x = r_x[j];
        w_gnt_p = r_p[j];
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_gnt_vld;
  assign w_apply = (r_state == S_IDLE) && r_cfg_pend;
  assign w_wb = (r_state == S_WAIT) && i_core_done &&
                !r_abort && !i_ch_clr[r_ch];
  assign w_tmo = (r_state == S_WAIT) && !i_core_done &&
                 (r_cnt == TLAST);
  assign w_abort_set = ((r_state == S_ISSUE) ||
                        (r_state == S_WAIT)) && i_ch_clr[r_ch];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt_vld) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_core_done)         w_state_nxt = S_WRITE;
        else if (r_cnt == TLAST) w_state_nxt = S_IDLE;
      end
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < N_CH; k++) begin
        r_meas[k] <= '0;
        r_x[k] <= '0;
        r_p[k] <= DW'(P_INIT);
      end
      r_pend <= '0;
      r_ovf <= '0;
      r_ch <= '0;
      r_last <= CW'(N_CH - 1);
      r_cnt <= '0;
      r_abort <= 1'b0;
      r_timeout <= 1'b0;
      r_cfg_pend <= 1'b0;
      r_q_act <= DW'(Q_INIT);
      r_r_act <= DW'(R_INIT);
      r_q_sh <= DW'(Q_INIT);
      r_r_sh <= DW'(R_INIT);
      r_op_meas <= '0;
      r_op_x <= '0;
      r_op_p <= '0;
      r_op_q <= DW'(Q_INIT);
      r_op_r <= DW'(R_INIT);
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (i_ch_clr[k]) begin
          r_x[k] <= '0;
          r_p[k] <= DW'(P_INIT);
          r_pend[k] <= 1'b0;
        end else begin
          if (w_wb && (r_ch == CW'(k))) begin
            r_x[k] <= i_core_x;
            r_p[k] <= i_core_p;
          end
          if (i_meas_vld[k]) r_meas[k] <= w_meas[k];
          if (w_grant && (w_gnt == CW'(k))) r_pend[k] <= 1'b0;
          else if (i_meas_vld[k])           r_pend[k] <= 1'b1;
        end
      end
      r_ovf <= (i_meas_vld & r_pend & ~i_ch_clr) |
               (r_ovf & ~{N_CH{i_ovf_clr}});
      r_timeout <= w_tmo | (r_timeout & ~i_ovf_clr);
      if (i_cfg_wr) begin
        r_q_sh <= i_cfg_Q;
        r_r_sh <= i_cfg_R;
      end
      if (w_apply) begin
        r_q_act <= r_q_sh;
        r_r_act <= r_r_sh;
      end
      r_cfg_pend <= i_cfg_wr | (r_cfg_pend & ~w_apply);
      // Operands freeze at grant so later config writes cannot disturb them.
      if (w_grant) begin
        r_ch <= w_gnt;
        r_last <= w_gnt;
        r_abort <= 1'b0;
        r_op_meas <= w_gnt_meas;
        r_op_x <= w_gnt_x;
        r_op_p <= w_gnt_p;
        r_op_q <= r_cfg_pend ? r_q_sh : r_q_act;
        r_op_r <= r_cfg_pend ? r_r_sh : r_r_act;
      end else if (w_abort_set) begin
        r_abort <= 1'b1;
      end
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + TW'(1);
    end
  end

  always_comb begin
    o_est_vld = '0;
    if ((r_state == S_WRITE) && !r_abort) o_est_vld[r_ch] = 1'b1;
  end

  assign o_core_start = (r_state == S_ISSUE);
  assign o_busy = (r_state != S_IDLE);
  assign o_core_meas = r_op_meas;
  assign o_core_x = r_op_x;
  assign o_core_p = r_op_p;
  assign o_core_Q = r_op_q;
  assign o_core_R = r_op_r;
  assign o_meas_ovf = r_ovf;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_kalman_scheduler.sv
// Directed bench for kalman_scheduler with a hand-driven core model.
// Expected values are hand-computed constants.
module tb_kalman_scheduler;

  localparam int N = 3;
  localparam int MW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] i_meas_vld = '0;
  logic [N*MW-1:0] i_meas = '0;
  logic [N-1:0] i_ch_clr = '0;
  logic i_cfg_wr = 1'b0;
  logic [DW-1:0] i_cfg_Q = '0;
  logic [DW-1:0] i_cfg_R = '0;
  logic i_ovf_clr = 1'b0;
  logic o_core_start;
  logic [MW-1:0] o_core_meas;
  logic [DW-1:0] o_core_x, o_core_p, o_core_Q, o_core_R;
  logic i_core_done = 1'b0;
  logic [DW-1:0] i_core_x = '0;
  logic [DW-1:0] i_core_p = '0;
  logic [N*DW-1:0] o_x_est, o_p_est;
  logic [N-1:0] o_est_vld, o_meas_ovf;
  logic o_timeout, o_busy;

  int n_tests = 0;
  int n_fail = 0;

  kalman_scheduler dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_meas_vld(i_meas_vld),
    .i_meas(i_meas),
    .i_ch_clr(i_ch_clr),
    .i_cfg_wr(i_cfg_wr),
    .i_cfg_Q(i_cfg_Q),
    .i_cfg_R(i_cfg_R),
    .i_ovf_clr(i_ovf_clr),
    .o_core_start(o_core_start),
    .o_core_meas(o_core_meas),
    .o_core_x(o_core_x),
    .o_core_p(o_core_p),
    .o_core_Q(o_core_Q),
    .o_core_R(o_core_R),
    .i_core_done(i_core_done),
    .i_core_x(i_core_x),
    .i_core_p(i_core_p),
    .o_x_est(o_x_est),
    .o_p_est(o_p_est),
    .o_est_vld(o_est_vld),
    .o_meas_ovf(o_meas_ovf),
    .o_timeout(o_timeout),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] xe(input int k);
    return o_x_est[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] pe(input int k);
    return o_p_est[k*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int k, input logic [MW-1:0] v);
    i_meas_vld[k] = 1'b1;
    i_meas[k*MW +: MW] = v;
    tick();
    i_meas_vld = '0;
  endtask

  task automatic issue_chk(input string tag, input logic [MW-1:0] m,
                           input logic [DW-1:0] xo, input logic [DW-1:0] po,
                           input logic [DW-1:0] q, input logic [DW-1:0] r);
    int n;
    n = 0;
    while (!o_core_start && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, o_core_start, 1);
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_meas"}, o_core_meas, m);
    chk({tag, "_x"}, o_core_x, xo);
    chk({tag, "_p"}, o_core_p, po);
    chk({tag, "_Q"}, o_core_Q, q);
    chk({tag, "_R"}, o_core_R, r);
  endtask

  task automatic finish_upd(input string tag, input int k,
                            input logic [DW-1:0] xr, input logic [DW-1:0] pr);
    logic [N-1:0] ev;
    ev = '0;
    ev[k] = 1'b1;
    i_core_done = 1'b1;
    i_core_x = xr;
    i_core_p = pr;
    tick();
    i_core_done = 1'b0;
    chk({tag, "_est_vld"}, o_est_vld, ev);
    chk({tag, "_x_est"}, xe(k), xr);
    chk({tag, "_p_est"}, pe(k), pr);
    tick();
    chk({tag, "_pulse"}, o_est_vld, 0);
    chk({tag, "_idle"}, o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, ev_cnt;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", o_busy, 0);
    chk("rst_start", o_core_start, 0);
    chk("rst_est_vld", o_est_vld, 0);
    chk("rst_ovf", o_meas_ovf, 0);
    chk("rst_tmo", o_timeout, 0);
    chk("rst_core_x", o_core_x, 0);
    chk("rst_core_Q", o_core_Q, 5);
    chk("rst_core_R", o_core_R, 10);
    for (int k = 0; k < N; k++) begin
      chk("rst_x", xe(k), 0);
      chk("rst_p", pe(k), 1);
    end

    // single update, done two cycles after start
    strobe(0, 14'd200);
    issue_chk("single", 14'd200, 0, 1, 5, 10);
    tick();
    tick();
    finish_upd("single", 0, 150, 3);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_x0", xe(0), 0);

    // round robin with minimum turnaround
    i_meas_vld = 3'b111;
    i_meas = {14'd33, 14'd22, 14'd11};
    tick();
    i_meas_vld = '0;
    issue_chk("rr0", 14'd11, 0, 1, 5, 10);
    tick();
    finish_upd("rr0", 0, 1000, 2);
    issue_chk("rr1", 14'd22, 0, 1, 5, 10);
    tick();
    finish_upd("rr1", 1, 2000, 4);
    issue_chk("rr2", 14'd33, 0, 1, 5, 10);
    strobe(0, 14'd44);
    finish_upd("rr2", 2, 3000, 6);
    issue_chk("rr0b", 14'd44, 1000, 2, 5, 10);
    tick();
    finish_upd("rr0b", 0, 1100, 7);

    // overflow on ch1 while ch2 is busy
    strobe(2, 14'd5);
    issue_chk("ovf2", 14'd5, 3000, 6, 5, 10);
    tick();
    strobe(1, 14'd100);
    strobe(1, 14'd300);
    finish_upd("ovf2", 2, 3100, 8);
    chk("ovf_set", o_meas_ovf, 3'b010);
    issue_chk("ovf1", 14'd300, 2000, 4, 5, 10);
    tick();
    finish_upd("ovf1", 1, 2100, 9);
    chk("ovf_sticky", o_meas_ovf, 3'b010);
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    chk("ovf_clr", o_meas_ovf, 0);

    // config shadowing
    strobe(0, 14'd55);
    issue_chk("cfg0", 14'd55, 1100, 7, 5, 10);
    tick();
    i_cfg_wr = 1'b1;
    i_cfg_Q = 32'd7;
    i_cfg_R = 32'd20;
    tick();
    i_cfg_wr = 1'b0;
    chk("cfg_hold_Q", o_core_Q, 5);
    chk("cfg_hold_R", o_core_R, 10);
    finish_upd("cfg0", 0, 1200, 11);
    strobe(1, 14'd66);
    issue_chk("cfg1", 14'd66, 2100, 9, 7, 20);
    tick();
    finish_upd("cfg1", 1, 2200, 12);

    // timeout
    strobe(2, 14'd77);
    issue_chk("tmo", 14'd77, 3100, 8, 7, 20);
    tick();
    n = 0;
    ev_cnt = 0;
    while (o_busy && n < 400) begin
      if (o_est_vld != 0) ev_cnt++;
      tick();
      n++;
    end
    chk("tmo_cycles", n, 255);
    chk("tmo_flag", o_timeout, 1);
    chk("tmo_no_est", ev_cnt, 0);
    chk("tmo_x2", xe(2), 3100);
    chk("tmo_p2", pe(2), 8);
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    chk("tmo_clr", o_timeout, 0);

    // clear while in flight
    strobe(0, 14'd88);
    issue_chk("clr", 14'd88, 1200, 11, 7, 20);
    tick();
    i_ch_clr = 3'b001;
    tick();
    i_ch_clr = '0;
    chk("clr_x0_now", xe(0), 0);
    i_core_done = 1'b1;
    i_core_x = 32'd999;
    i_core_p = 32'd99;
    tick();
    i_core_done = 1'b0;
    chk("clr_no_est", o_est_vld, 0);
    chk("clr_write_busy", o_busy, 1);
    tick();
    chk("clr_x0", xe(0), 0);
    chk("clr_p0", pe(0), 1);
    chk("clr_idle", o_busy, 0);

    // stray done in IDLE
    i_core_done = 1'b1;
    i_core_x = 32'd5555;
    tick();
    i_core_done = 1'b0;
    chk("stray_est", o_est_vld, 0);
    chk("stray_x1", xe(1), 2200);
    chk("stray_busy", o_busy, 0);

    // reset mid-operation
    strobe(1, 14'd5);
    issue_chk("mrst", 14'd5, 2200, 12, 7, 20);
    tick();
    rst = 1'b1;
    #2;
    chk("mrst_busy", o_busy, 0);
    chk("mrst_x1", xe(1), 0);
    chk("mrst_p1", pe(1), 1);
    chk("mrst_Q", o_core_Q, 5);
    chk("mrst_core_x", o_core_x, 0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
